// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: everything the ID side drives into the pipeline register
// plus everything the register presents to EX.
//   master : ID-side driver (decoder/regfile/hazard sources); reads EX outputs
//   slave  : the id_ex_stage register itself
// Inputs:  hold_i, flush_i, id_valid_i, decoder controls, pc/operands/imm,
//          funct, register addresses.
// Outputs: registered controls/data/addresses, valid_o, hazard_o, bubble_cnt_o.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             hold_i;
  logic             flush_i;
  logic             id_valid_i;
  logic [1:0]       ALUOp_i;
  logic             ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
  logic [XLEN-1:0]  pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [9:0]       funct_i;
  logic [4:0]       rs1_i, rs2_i, rd_i;

  logic [1:0]       ALUOp_o;
  logic             ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o;
  logic [XLEN-1:0]  pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]       funct_o;
  logic [4:0]       rs1_o, rs2_o, rd_o;
  logic             valid_o;
  logic             hazard_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output hold_i, flush_i, id_valid_i, ALUOp_i, ALUSrc_i, Branch_i, MemRead_i,
           MemWrite_i, RegWrite_i, MemtoReg_i, pc_i, rs1_data_i, rs2_data_i,
           imm_i, funct_i, rs1_i, rs2_i, rd_i,
    input  ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o,
           MemtoReg_o, pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_o,
           rs2_o, rd_o, valid_o, hazard_o, bubble_cnt_o
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, ALUOp_i, ALUSrc_i, Branch_i, MemRead_i,
           MemWrite_i, RegWrite_i, MemtoReg_i, pc_i, rs1_data_i, rs2_data_i,
           imm_i, funct_i, rs1_i, rs2_i, rd_i,
    output ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o,
           MemtoReg_o, pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_o,
           rs2_o, rd_o, valid_o, hazard_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset, dominates everything
//   bus   : id_ex_stage_if.slave (ID inputs, EX outputs, hazard_o, bubble count)
// Edge priority: reset > hold (freeze) > flush (bubble) > load-use (bubble,
// counted) > normal load. A bubble is the all-zero record.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [9:0]      funct;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
  } ex_t;

  ex_t              ex_q, ex_in;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard;

  // Incoming record. A non-valid ID slot is loaded as a full bubble so that
  // nothing downstream ever sees stale controls or a write-back target.
  always_comb begin
    ex_in = '0;
    if (bus.id_valid_i) begin
      ex_in.alu_op     = bus.ALUOp_i;
      ex_in.alu_src    = bus.ALUSrc_i;
      ex_in.branch     = bus.Branch_i;
      ex_in.mem_read   = bus.MemRead_i;
      ex_in.mem_write  = bus.MemWrite_i;
      ex_in.reg_write  = bus.RegWrite_i;
      // Decoder leaves MemtoReg as don't-care for stores/branches.
      ex_in.mem_to_reg = bus.MemtoReg_i & bus.RegWrite_i;
      ex_in.pc         = bus.pc_i;
      ex_in.rs1_data   = bus.rs1_data_i;
      ex_in.rs2_data   = bus.rs2_data_i;
      ex_in.imm        = bus.imm_i;
      ex_in.funct      = bus.funct_i;
      ex_in.rs1        = bus.rs1_i;
      ex_in.rs2        = bus.rs2_i;
      ex_in.rd         = bus.rd_i;
      ex_in.valid      = 1'b1;
    end
  end

  // Load in EX whose destination is read by the ID instruction. Both source
  // fields are compared regardless of format; a spurious stall is harmless.
  // A flush squashes the ID instruction anyway, so no stall is requested.
  assign hazard = bus.id_valid_i & ~bus.flush_i & ex_q.mem_read & ex_q.valid &
                  (ex_q.rd != 5'd0) &
                  ((ex_q.rd == bus.rs1_i) | (ex_q.rd == bus.rs2_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (bus.hold_i) begin
      ex_q  <= ex_q;
    end else if (bus.flush_i) begin
      ex_q  <= '0;
    end else if (hazard) begin
      ex_q  <= '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      ex_q  <= ex_in;
    end
  end

  assign bus.ALUOp_o      = ex_q.alu_op;
  assign bus.ALUSrc_o     = ex_q.alu_src;
  assign bus.Branch_o     = ex_q.branch;
  assign bus.MemRead_o    = ex_q.mem_read;
  assign bus.MemWrite_o   = ex_q.mem_write;
  assign bus.RegWrite_o   = ex_q.reg_write;
  assign bus.MemtoReg_o   = ex_q.mem_to_reg;
  assign bus.pc_o         = ex_q.pc;
  assign bus.rs1_data_o   = ex_q.rs1_data;
  assign bus.rs2_data_o   = ex_q.rs2_data;
  assign bus.imm_o        = ex_q.imm;
  assign bus.funct_o      = ex_q.funct;
  assign bus.rs1_o        = ex_q.rs1;
  assign bus.rs2_o        = ex_q.rs2;
  assign bus.rd_o         = ex_q.rd;
  assign bus.valid_o      = ex_q.valid;
  assign bus.hazard_o     = hazard;
  assign bus.bubble_cnt_o = cnt_q;

endmodule
